// File: rtl/draw_bus_pkg.sv
// Geometry and sequencer types shared by the draw units and the draw-source write bus.
package draw_bus_pkg;

    localparam int unsigned COLOR_DEPTH       = 9;
    localparam int unsigned DRAW_WIDTH        = 160;
    localparam int unsigned DRAW_HEIGHT       = 120;
    localparam int unsigned DRAW_WIDTH_ADDRW  = $clog2(DRAW_WIDTH);
    localparam int unsigned DRAW_HEIGHT_ADDRW = $clog2(DRAW_HEIGHT);
    localparam int unsigned BUF_ADDRW         = $clog2(DRAW_WIDTH * DRAW_HEIGHT);

    // Source-select width; a single source still needs one bit.
    function automatic int unsigned sel_addrw(input int unsigned max_source);
        return (max_source == 0) ? 32'd1 : 32'($clog2(max_source + 1));
    endfunction

    typedef enum logic [2:0] {IDLE, GRANT, STREAM, ADVANCE, SWAP} seq_state_t;

endpackage

// File: rtl/pixel_commit.sv
// One-cycle write stage: range check, transparency filter and y*W+x address into the back buffer.
module pixel_commit
    import draw_bus_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         valid_i,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  x_i,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] y_i,
    input  logic [COLOR_DEPTH-1:0]       color_i,
    input  logic                         transparent_i,
    output logic                         we_o,
    output logic [BUF_ADDRW-1:0]         addr_o,
    output logic [COLOR_DEPTH-1:0]       data_o
);

    logic                   we_d, we_q;
    logic [BUF_ADDRW-1:0]   addr_d, addr_q;
    logic [COLOR_DEPTH-1:0] data_d, data_q;
    logic                   in_range;

    always_comb begin
        in_range = (32'(x_i) < DRAW_WIDTH) && (32'(y_i) < DRAW_HEIGHT);
        we_d     = valid_i && !transparent_i && in_range;
        addr_d   = addr_q;
        data_d   = data_q;
        if (we_d) begin
            addr_d = BUF_ADDRW'(y_i) * BUF_ADDRW'(DRAW_WIDTH) + BUF_ADDRW'(x_i);
            data_d = color_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/draw_source_sequencer.sv
// Grants the draw bus to each source in ascending order once per frame, commits their pixels
// into the back buffer and requests a buffer swap once every source has finished.
module draw_source_sequencer
    import draw_bus_pkg::*;
#(
    parameter int unsigned MAX_WRITE_SOURCE = 2,
    parameter int unsigned GRANT_TIMEOUT    = 1024,
    localparam int unsigned SOURCE_SEL_ADDRW = sel_addrw(MAX_WRITE_SOURCE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame,
    output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    output logic                         write_awaited,
    input  logic                         write_active,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
    input  logic [COLOR_DEPTH-1:0]       write_color_data,
    input  logic                         write_transparent,
    output logic                         buf_we,
    output logic [BUF_ADDRW-1:0]         buf_addr,
    output logic [COLOR_DEPTH-1:0]       buf_data,
    output logic                         swap_req,
    output logic                         overrun
);

    localparam int unsigned TMO_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

    seq_state_t                  state_d, state_q;
    logic [SOURCE_SEL_ADDRW-1:0] sel_d, sel_q;
    logic [TMO_W-1:0]            tmo_d, tmo_q;
    logic                        awaited_d, awaited_q;
    logic                        pending_d, pending_q;
    logic                        swap_req_d, swap_req_q;
    logic                        overrun_d, overrun_q;
    logic                        last_source;

    assign last_source = (32'(sel_q) >= MAX_WRITE_SOURCE);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        tmo_d      = tmo_q;
        awaited_d  = awaited_q;
        pending_d  = pending_q;
        swap_req_d = 1'b0;
        overrun_d  = 1'b0;

        // A frame during a pass is remembered, never allowed to interrupt it.
        if (frame && (state_q != IDLE)) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (frame || pending_q) begin
                    sel_d     = '0;
                    awaited_d = 1'b1;
                    pending_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (write_active) begin
                    state_d = STREAM;
                end else if (tmo_q == TMO_W'(GRANT_TIMEOUT - 1)) begin
                    awaited_d = 1'b0;
                    state_d   = ADVANCE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            STREAM: begin
                if (!write_active) begin
                    awaited_d = 1'b0;
                    state_d   = ADVANCE;
                end
            end
            ADVANCE: begin
                if (!last_source) begin
                    sel_d     = sel_q + 1'b1;
                    awaited_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = GRANT;
                end else begin
                    swap_req_d = 1'b1;
                    state_d    = SWAP;
                end
            end
            SWAP: begin
                sel_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            tmo_q      <= '0;
            awaited_q  <= 1'b0;
            pending_q  <= 1'b0;
            swap_req_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            tmo_q      <= tmo_d;
            awaited_q  <= awaited_d;
            pending_q  <= pending_d;
            swap_req_q <= swap_req_d;
            overrun_q  <= overrun_d;
        end
    end

    // The bus is only looked at while the current source holds the grant.
    pixel_commit u_pixel_commit (
        .clk_i         (clk),
        .reset_i       (reset),
        .valid_i       (awaited_q && write_active),
        .x_i           (write_x_addr),
        .y_i           (write_y_addr),
        .color_i       (write_color_data),
        .transparent_i (write_transparent),
        .we_o          (buf_we),
        .addr_o        (buf_addr),
        .data_o        (buf_data)
    );

    assign write_source_sel = sel_q;
    assign write_awaited    = awaited_q;
    assign swap_req         = swap_req_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_draw_source_sequencer.sv
// Scoreboard bench: the driver predicts back-buffer writes from pixel rules, a monitor checks them.
module tb_draw_source_sequencer;
    import draw_bus_pkg::*;

    localparam int unsigned TMO = 1024;
    localparam int unsigned SW2 = sel_addrw(2);
    localparam int unsigned SW0 = sel_addrw(0);

    typedef struct packed {
        int unsigned addr;
        int unsigned data;
        int unsigned cyc;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame = 1'b0, frame0 = 1'b0;
    logic wa = 1'b0, wa0 = 1'b0, wt = 1'b0;
    logic [DRAW_WIDTH_ADDRW-1:0]  wx = '0;
    logic [DRAW_HEIGHT_ADDRW-1:0] wy = '0;
    logic [COLOR_DEPTH-1:0]       wc = '0;

    logic [SW2-1:0]         sel;
    logic                   awaited, buf_we, swap_req, overrun;
    logic [BUF_ADDRW-1:0]   buf_addr;
    logic [COLOR_DEPTH-1:0] buf_data;
    logic [SW0-1:0]         sel0;
    logic                   awaited0, buf_we0, swap0, overrun0;
    logic [BUF_ADDRW-1:0]   buf_addr0;
    logic [COLOR_DEPTH-1:0] buf_data0;

    int unsigned cyc = 0;
    int compared = 0, mismatched = 0;
    int swaps = 0, swaps0 = 0, overruns = 0;

    draw_source_sequencer #(.MAX_WRITE_SOURCE(2), .GRANT_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .frame(frame), .write_source_sel(sel), .write_awaited(awaited),
        .write_active(wa), .write_x_addr(wx), .write_y_addr(wy), .write_color_data(wc),
        .write_transparent(wt), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
        .swap_req(swap_req), .overrun(overrun)
    );

    draw_source_sequencer #(.MAX_WRITE_SOURCE(0), .GRANT_TIMEOUT(TMO)) dut0 (
        .clk(clk), .reset(reset), .frame(frame0), .write_source_sel(sel0),
        .write_awaited(awaited0), .write_active(wa0), .write_x_addr(wx), .write_y_addr(wy),
        .write_color_data(wc), .write_transparent(wt), .buf_we(buf_we0), .buf_addr(buf_addr0),
        .buf_data(buf_data0), .swap_req(swap0), .overrun(overrun0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write, otherwise the address/data must hold.
    logic rst_s = 1'b1;
    int unsigned last_addr = 0, last_data = 0;
    always @(posedge clk) rst_s <= reset;

    always @(negedge clk) begin
        exp_t e;
        if (rst_s) begin
            last_addr = 0;
            last_data = 0;
        end
        if (buf_we === 1'b1) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got write addr %0d, expected none", buf_addr);
            end else begin
                e = q.pop_front();
                check("wr_addr", buf_addr, e.addr);
                check("wr_data", buf_data, e.data);
                check("wr_latency", cyc, e.cyc);
                last_addr = e.addr;
                last_data = e.data;
            end
        end else if (!rst_s) begin
            check("addr_hold", buf_addr, last_addr);
            check("data_hold", buf_data, last_data);
        end
        if (buf_we0 === 1'b1) begin
            if (q0.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write0: got write addr %0d, expected none", buf_addr0);
            end else begin
                e = q0.pop_front();
                check("wr0_addr", buf_addr0, e.addr);
                check("wr0_data", buf_data0, e.data);
                check("wr0_latency", cyc, e.cyc);
            end
        end
        if (swap_req === 1'b1) swaps++;
        if (swap0 === 1'b1) swaps0++;
        if (overrun === 1'b1) overruns++;
    end

    task automatic drive_pixel(input bit d0, input int unsigned x, input int unsigned y,
                               input int unsigned c, input bit t);
        exp_t e;
        wx = DRAW_WIDTH_ADDRW'(x);
        wy = DRAW_HEIGHT_ADDRW'(y);
        wc = COLOR_DEPTH'(c);
        wt = t;
        if (d0) wa0 = 1'b1; else wa = 1'b1;
        if (!t && x < DRAW_WIDTH && y < DRAW_HEIGHT) begin
            e.addr = y * DRAW_WIDTH + x;
            e.data = c;
            e.cyc  = cyc + 1;
            if (d0) q0.push_back(e); else q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic stream(input bit d0, input int n, input int ovr_at);
        for (int i = 0; i < n; i++) begin
            if (i == ovr_at) frame = 1'b1;
            drive_pixel(d0, $urandom_range(0, 169), $urandom_range(0, 127),
                        $urandom_range(0, 511), ($urandom_range(0, 3) == 0));
            if (i == ovr_at) begin
                frame = 1'b0;
                check("overrun_pulse", overrun, 1);
            end
        end
    endtask

    task automatic end_source(input bit d0);
        if (d0) wa0 = 1'b0; else wa = 1'b0;
        @(negedge clk);
        check("grant_bubble", d0 ? awaited0 : awaited, 0);
    endtask

    task automatic wait_grant(input bit d0, input int unsigned exp_sel, input int unsigned exp_wait,
                              input string name);
        int unsigned n = 0;
        while (((d0 ? awaited0 : awaited) !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_wait"}, n, exp_wait);
        check({name, "_sel"}, d0 ? sel0 : sel, exp_sel);
    endtask

    task automatic run_source(input int unsigned s, input int unsigned w, input int n,
                              input int ovr_at, input string name);
        wait_grant(1'b0, s, w, name);
        stream(1'b0, n, ovr_at);
        end_source(1'b0);
    endtask

    task automatic pulse_frame(input bit d0);
        if (d0) frame0 = 1'b1; else frame = 1'b1;
        @(negedge clk);
        frame  = 1'b0;
        frame0 = 1'b0;
    endtask

    task automatic check_reset(input string name);
        check({name, "_sel"}, sel, 0);
        check({name, "_awaited"}, awaited, 0);
        check({name, "_we"}, buf_we, 0);
        check({name, "_addr"}, buf_addr, 0);
        check({name, "_data"}, buf_data, 0);
        check({name, "_swap"}, swap_req, 0);
        check({name, "_overrun"}, overrun, 0);
    endtask

    task automatic check_swap(input string name);
        @(negedge clk);
        check({name, "_swap"}, swap_req, 1);
        @(negedge clk);
        check({name, "_swap_end"}, swap_req, 0);
        check({name, "_sel_idle"}, sel, 0);
    endtask

    initial begin
        int unsigned n;
        repeat (3) @(negedge clk);
        check_reset("por");
        reset = 1'b0;

        // Bus activity with no grant must be ignored.
        wa = 1'b1; wx = 10; wy = 10; wc = 9'h055; wt = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_awaited", awaited, 0);
        wa = 1'b0;

        // Pass 1: directed pixels, source 1 times out.
        pulse_frame(1'b0);
        wait_grant(1'b0, 0, 0, "p1_s0");
        drive_pixel(1'b0, 3, 2, 'h1FF, 1'b0);
        drive_pixel(1'b0, 7, 7, 'h0AA, 1'b1);
        drive_pixel(1'b0, 160, 5, 'h123, 1'b0);
        drive_pixel(1'b0, 159, 119, 'h0F0, 1'b0);
        stream(1'b0, 10, -1);
        end_source(1'b0);
        wait_grant(1'b0, 1, 1, "p1_s1");
        n = 0;
        while (!(awaited === 1'b1 && sel == 2) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TMO + 1);
        stream(1'b0, 15, -1);
        end_source(1'b0);
        check_swap("p1");
        #1 check("p1_swap_count", swaps, 1);

        // Pass 2: frames during STREAM and during SWAP collapse into one pending pass.
        pulse_frame(1'b0);
        run_source(0, 0, 5, -1, "p2_s0");
        run_source(1, 1, 8, 3, "p2_s1");
        run_source(2, 1, 6, -1, "p2_s2");
        @(negedge clk);
        check("p2_swap", swap_req, 1);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        check("p2_swap_end", swap_req, 0);
        check("p2_overrun_at_swap", overrun, 1);
        check("p2_idle_awaited", awaited, 0);

        // Pass 3 starts from the pending flag alone.
        run_source(0, 1, 3, -1, "p3_s0");
        run_source(1, 1, 3, -1, "p3_s1");
        run_source(2, 1, 3, -1, "p3_s2");
        check_swap("p3");
        repeat (20) @(negedge clk);
        check("no_extra_pass", awaited, 0);
        #1 check("p3_swap_count", swaps, 3);
        check("overrun_count", overruns, 2);

        // Pass 4: reset while source 2 streams.
        pulse_frame(1'b0);
        run_source(0, 0, 4, -1, "p4_s0");
        run_source(1, 1, 4, -1, "p4_s1");
        wait_grant(1'b0, 2, 1, "p4_s2");
        stream(1'b0, 3, -1);
        reset = 1'b1; wa = 1'b1; wx = 20; wy = 20; wc = 9'h077; wt = 1'b0;
        @(negedge clk);
        check_reset("mid_reset");
        reset = 1'b0;
        wa = 1'b0;
        repeat (30) @(negedge clk);
        check("post_reset_awaited", awaited, 0);
        #1 check("post_reset_swaps", swaps, 3);

        // Pass 5: full pass after reset.
        pulse_frame(1'b0);
        run_source(0, 0, 4, -1, "p5_s0");
        run_source(1, 1, 4, -1, "p5_s1");
        run_source(2, 1, 4, -1, "p5_s2");
        check_swap("p5");
        #1 check("p5_swap_count", swaps, 4);

        // Single-source build.
        pulse_frame(1'b1);
        wait_grant(1'b1, 0, 0, "m0");
        drive_pixel(1'b1, 0, 0, 'h001, 1'b0);
        drive_pixel(1'b1, 159, 0, 'h002, 1'b0);
        drive_pixel(1'b1, 0, 119, 'h003, 1'b0);
        drive_pixel(1'b1, 80, 60, 'h1A5, 1'b0);
        end_source(1'b1);
        @(negedge clk);
        check("m0_swap", swap0, 1);

        repeat (3) @(negedge clk);
        #1;
        check("m0_swap_count", swaps0, 1);
        check("final_overruns", overruns, 2);
        check("q_drained", q.size(), 0);
        check("q0_drained", q0.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got no finish, expected finish within 500us");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/draw_source_sequencer.md
Name: draw_source_sequencer

Overview:
Responder end of the draw-source write bus. Grants the bus to each draw source in turn, 0..MAX_WRITE_SOURCE, once per frame, and commits their non-transparent pixels into the back frame buffer. It requests a front/back swap when every source has finished. It sits between the draw units (background, starfield, gsensor calibration) and the dual-buffer memory, on the draw clock.

Parameters:
MAX_WRITE_SOURCE, 2, highest source ID; sources 0..MAX_WRITE_SOURCE are served in ascending order.
DRAW_WIDTH, 160, draw-plane width in pixels.
DRAW_HEIGHT, 120, draw-plane height in pixels.
COLOR_DEPTH, 9, bits per pixel (3 per channel).
GRANT_TIMEOUT, 1024, cycles a granted source has to raise write_active before it is skipped.

Ports:
clk  in  1  draw clock (25 MHz); the single clock domain.
reset  in  1  synchronous, active-high reset.
frame  in  1  one-cycle pulse at the display end of frame.
write_source_sel  out  SOURCE_SEL_ADDRW  ID of the granted source.
write_awaited  out  1  high while the granted source may stream pixels.
write_active  in  1  driven by the granted source; high for each valid pixel, low once the source is done.
write_x_addr  in  DRAW_WIDTH_ADDRW  pixel x.
write_y_addr  in  DRAW_HEIGHT_ADDRW  pixel y.
write_color_data  in  COLOR_DEPTH  pixel colour.
write_transparent  in  1  pixel is not written when high.
buf_we  out  1  back-buffer write enable.
buf_addr  out  BUF_ADDRW  y*DRAW_WIDTH + x.
buf_data  out  COLOR_DEPTH  colour to write.
swap_req  out  1  one-cycle pulse: back buffer complete, swap at the next frame.
overrun  out  1  one-cycle pulse: a frame arrived while a drawing pass was still in progress.

Behaviour:
- Reset: state IDLE, write_source_sel=0, write_awaited=0, buf_we=0, buf_addr=0, buf_data=0, swap_req=0, overrun=0, internal pending/timeout counters cleared. Reset mid-pass abandons the pass; no swap is issued.
- Bus rules:
  - All outputs are registered.
  - write_* inputs are sampled only while write_awaited=1.
  - write_active from any non-granted source is ignored, because the sources share the bus by write_source_sel.
- IDLE: on frame, or pending-frame flag set: sel<=0, awaited<=1, clear the flag and timeout counter, go to GRANT.
- GRANT: awaited=1.
  - write_active=1 -> STREAM; the pixel on that cycle is committed.
  - Timeout counter reaches GRANT_TIMEOUT-1 with write_active still 0 -> ADVANCE; the source is skipped.
- STREAM:
  - Each cycle with write_active=1, !write_transparent, x<DRAW_WIDTH and y<DRAW_HEIGHT: next cycle buf_we=1, buf_addr=y*DRAW_WIDTH+x, buf_data=colour. Latency is exactly 1 cycle.
  - A transparent or out-of-range pixel gives buf_we=0.
  - write_active=0 -> ADVANCE.
- ADVANCE: awaited<=0 for one cycle (bubble, so a source sees the grant drop before the next one starts).
  - sel<MAX_WRITE_SOURCE: sel<=sel+1, awaited<=1, -> GRANT.
  - Otherwise -> SWAP.
- SWAP: swap_req=1 for one cycle, sel<=0, -> IDLE.
- Frame outside IDLE: overrun pulses the next cycle and the pending flag is set; the pass continues uninterrupted. Multiple overruns collapse into one pending flag.
- Frame in the same cycle as SWAP: the swap is still issued; the pending flag starts the next pass immediately from IDLE.
- Address arithmetic:
  - y*DRAW_WIDTH computed at BUF_ADDRW width; no truncation for legal coordinates.
  - Maximum address = DRAW_WIDTH*DRAW_HEIGHT-1 = 19199.
  - buf_addr holds its last value when buf_we=0.
- MAX_WRITE_SOURCE=0 is legal: one GRANT/STREAM pass, then SWAP.

Decomposition:
- Shared package draw_bus_pkg:
  - COLOR_DEPTH, DRAW_WIDTH, DRAW_HEIGHT.
  - DRAW_WIDTH_ADDRW=$clog2(DRAW_WIDTH), DRAW_HEIGHT_ADDRW=$clog2(DRAW_HEIGHT).
  - SOURCE_SEL_ADDRW=$clog2(MAX_WRITE_SOURCE+1), min 1.
  - BUF_ADDRW=$clog2(DRAW_WIDTH*DRAW_HEIGHT).
  - seq_state_t enum {IDLE, GRANT, STREAM, ADVANCE, SWAP}.
- One sub-module: pixel_commit, which does the range check, transparency filter, address multiply and output register (the 1-cycle write stage).

Test Plan:
- Reset then frame; source 0 streams (3,2,9'h1FF) then drops write_active -> buf_we one cycle later, buf_addr=323, buf_data=9'h1FF; sel advances 0->1 after a 1-cycle awaited=0 bubble.
- Pixel with write_transparent=1, and pixel x=160 -> buf_we stays 0; the following legal pixel (159,119) -> buf_addr=19199.
- Source 1 never asserts write_active -> after 1024 cycles in GRANT, sel=2; with sources 0 and 2 finishing, swap_req pulses exactly once.
- Second frame pulse during STREAM of source 1 -> overrun pulse; the pass completes with swap_req; the new pass starts the cycle after SWAP, sel=0.
- Reset asserted in STREAM with source 2 granted -> next cycle all outputs at reset values; no swap_req until a full pass follows the next frame.
- MAX_WRITE_SOURCE=0 build: frame, source 0 streams 4 pixels -> 4 writes, then swap_req.
